// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave with stream-style TX/RX word queues.
module spi_slave #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] miso_stream_tdata,
    input  logic                  miso_stream_tvalid,
    output logic                  miso_stream_tready,
    output logic [DATA_WIDTH-1:0] mosi_stream_tdata,
    output logic                  mosi_stream_tvalid,
    input  logic                  mosi_stream_tready,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sck_d;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_sr;
    logic [DATA_WIDTH-1:0]  tx_sr;
    logic                   reload_pending;

    logic                  cs_s, sck_s, mosi_s;
    logic                  cs_fall, cs_rise, sck_rise, sck_fall;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] rx_word;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign rx_word  = {rx_sr[DATA_WIDTH-2:0], mosi_s};

    // A final sck fall that coincides with cs rising ends the frame; it must not pull another TX word.
    assign tx_load = ((state == IDLE) && cs_fall && armed) ||
                     ((state == ACTIVE) && sck_fall && reload_pending && !cs_rise);

    assign miso_stream_tready = tx_load & miso_stream_tvalid;
    assign miso_oe            = (state == ACTIVE);
    assign miso               = (state == ACTIVE) & tx_sr[DATA_WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cs_sync            <= '1;
            sck_sync           <= '0;
            mosi_sync          <= '0;
            cs_d               <= 1'b1;
            sck_d              <= 1'b0;
            fill               <= '0;
            armed              <= 1'b0;
            bit_cnt            <= '0;
            rx_sr              <= '0;
            tx_sr              <= '0;
            reload_pending     <= 1'b0;
            mosi_stream_tdata  <= '0;
            mosi_stream_tvalid <= 1'b0;
            overrun            <= 1'b0;
            underrun           <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_d      <= cs_s;
            sck_d     <= sck_s;
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
            // Only a cs high seen after the pipeline refilled arms framing, so a cs held low through reset is ignored.
            armed     <= armed | (fill[SYNC_STAGES] & cs_s);
            overrun   <= 1'b0;
            underrun  <= 1'b0;

            if (mosi_stream_tvalid && mosi_stream_tready)
                mosi_stream_tvalid <= 1'b0;

            if (tx_load) begin
                tx_sr    <= miso_stream_tvalid ? miso_stream_tdata : IDLE_WORD;
                underrun <= ~miso_stream_tvalid;
            end

            case (state)
                IDLE: begin
                    bit_cnt        <= '0;
                    reload_pending <= 1'b0;
                    if (cs_fall && armed)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state          <= IDLE;
                        bit_cnt        <= '0;
                        rx_sr          <= '0;
                        reload_pending <= 1'b0;
                    end else begin
                        if (sck_rise) begin
                            rx_sr <= rx_word;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt        <= '0;
                                reload_pending <= 1'b1;
                                if (!mosi_stream_tvalid || mosi_stream_tready) begin
                                    mosi_stream_tdata  <= rx_word;
                                    mosi_stream_tvalid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (sck_fall) begin
                            if (!reload_pending)
                                tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                            reload_pending <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] tx_tdata;
    logic       tx_tvalid, tx_tready;
    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_ready = 1'b1;
    logic       overrun, underrun;

    logic [7:0] tx_words [0:15];
    int         tx_cnt = 0;
    int         tx_idx = 0;
    bit         pop_pending = 1'b0;
    logic [7:0] beats [0:31];
    int         rx_n = 0;
    int         tready_n = 0;
    int         under_n = 0;
    int         over_n = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign tx_tvalid = (tx_idx < tx_cnt);
    assign tx_tdata  = tx_words[tx_idx[3:0]];

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
        .clk                (clk),
        .reset              (reset),
        .cs                 (cs),
        .sck                (sck),
        .mosi               (mosi),
        .miso               (miso),
        .miso_oe            (miso_oe),
        .miso_stream_tdata  (tx_tdata),
        .miso_stream_tvalid (tx_tvalid),
        .miso_stream_tready (tx_tready),
        .mosi_stream_tdata  (rx_tdata),
        .mosi_stream_tvalid (rx_tvalid),
        .mosi_stream_tready (rx_ready),
        .overrun            (overrun),
        .underrun           (underrun)
    );

    always @(negedge clk) begin
        if (pop_pending) begin
            tx_idx++;
            pop_pending = 1'b0;
        end
        if (tx_tready && tx_tvalid) begin
            tready_n++;
            pop_pending = 1'b1;
        end
        if (rx_tvalid && rx_ready) begin
            beats[rx_n[4:0]] = rx_tdata;
            rx_n++;
        end
        if (underrun) under_n++;
        if (overrun)  over_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, input bit end_cs, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(4);
            sck = 1'b1;
            rx[7-i] = miso;
            wait_clk(4);
            sck = 1'b0;
            if (end_cs && i == nbits - 1) cs = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rx;
        int b0, t0, u0, o0;

        wait_clk(3);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_rx_tvalid", {31'd0, rx_tvalid}, 32'd0);
        chk("rst_rx_tdata", {24'd0, rx_tdata}, 32'd0);
        chk("rst_flags", {29'd0, tx_tready, overrun, underrun}, 32'd0);
        reset = 1'b0;
        wait_clk(6);

        // Single word, TX 0xA5, RX 0x3C
        tx_words[0] = 8'hA5; tx_cnt = 1;
        b0 = rx_n; t0 = tready_n; u0 = under_n;
        cs = 1'b0;
        wait_clk(4);
        chk("a5_oe_active", {31'd0, miso_oe}, 32'd1);
        chk("a5_first_bit", {31'd0, miso}, 32'd1);
        xfer(8'h3C, 8, 1'b1, rx);
        wait_clk(12);
        chk("a5_miso", {24'd0, rx}, 32'hA5);
        chk("a5_beats", rx_n - b0, 1);
        chk("a5_beat_data", {24'd0, beats[b0[4:0]]}, 32'h3C);
        chk("a5_tready_pulses", tready_n - t0, 1);
        chk("a5_no_underrun", under_n - u0, 0);
        chk("idle_oe", {31'd0, miso_oe}, 32'd0);
        chk("idle_miso", {31'd0, miso}, 32'd0);

        // Empty TX queue
        b0 = rx_n; t0 = tready_n; u0 = under_n;
        cs = 1'b0;
        xfer(8'h00, 8, 1'b1, rx);
        wait_clk(12);
        chk("empty_miso", {24'd0, rx}, 32'hFF);
        chk("empty_underrun", under_n - u0, 1);
        chk("empty_tready", tready_n - t0, 0);
        chk("empty_beat", {24'd0, beats[b0[4:0]]}, 32'h00);

        // Back-to-back words under one cs
        tx_words[1] = 8'h11; tx_words[2] = 8'h22; tx_cnt = 3;
        b0 = rx_n; t0 = tready_n;
        cs = 1'b0;
        xfer(8'h81, 8, 1'b0, rx);
        chk("b2b_miso0", {24'd0, rx}, 32'h11);
        xfer(8'h42, 8, 1'b1, rx);
        chk("b2b_miso1", {24'd0, rx}, 32'h22);
        wait_clk(12);
        chk("b2b_beats", rx_n - b0, 2);
        chk("b2b_beat0", {24'd0, beats[b0[4:0]]}, 32'h81);
        chk("b2b_beat1", {24'd0, beats[(b0 + 1) % 32]}, 32'h42);
        chk("b2b_tready", tready_n - t0, 2);

        // Overrun with sink stalled
        rx_ready = 1'b0;
        b0 = rx_n; o0 = over_n;
        cs = 1'b0;
        xfer(8'h01, 8, 1'b0, rx);
        xfer(8'h02, 8, 1'b1, rx);
        wait_clk(12);
        chk("ovr_tdata", {24'd0, rx_tdata}, 32'h01);
        chk("ovr_tvalid", {31'd0, rx_tvalid}, 32'd1);
        chk("ovr_pulses", over_n - o0, 1);
        rx_ready = 1'b1;
        wait_clk(4);
        chk("ovr_beats", rx_n - b0, 1);
        chk("ovr_beat_data", {24'd0, beats[b0[4:0]]}, 32'h01);
        chk("ovr_tvalid_clr", {31'd0, rx_tvalid}, 32'd0);

        // Partial word aborted by cs, then a full word
        b0 = rx_n;
        cs = 1'b0;
        xfer(8'hF0, 5, 1'b1, rx);
        wait_clk(12);
        chk("partial_no_beat", rx_n - b0, 0);
        cs = 1'b0;
        xfer(8'h5A, 8, 1'b1, rx);
        wait_clk(12);
        chk("partial_next_beats", rx_n - b0, 1);
        chk("partial_next_data", {24'd0, beats[b0[4:0]]}, 32'h5A);

        // Reset mid-transfer with cs held low
        b0 = rx_n;
        cs = 1'b0;
        xfer(8'hE0, 3, 1'b0, rx);
        reset = 1'b1;
        wait_clk(2);
        chk("midrst_miso_oe", {30'd0, miso, miso_oe}, 32'd0);
        chk("midrst_rx", {23'd0, rx_tvalid, rx_tdata}, 32'd0);
        chk("midrst_flags", {29'd0, tx_tready, overrun, underrun}, 32'd0);
        reset = 1'b0;
        wait_clk(6);
        xfer(8'hFF, 8, 1'b0, rx);
        wait_clk(12);
        chk("midrst_ignored_beats", rx_n - b0, 0);
        chk("midrst_ignored_oe", {31'd0, miso_oe}, 32'd0);
        cs = 1'b1;
        wait_clk(10);
        cs = 1'b0;
        xfer(8'hC3, 8, 1'b1, rx);
        wait_clk(12);
        chk("midrst_fresh_beats", rx_n - b0, 1);
        chk("midrst_fresh_data", {24'd0, beats[b0[4:0]]}, 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
